fx2fp_batch_ctrl: RTL
=====================

// Module: fx2fp_batch_ctrl
// PURPOSE
// Sequencer that runs the fixed(8.8)->float16 converter datapath over a batch of operands in the byte-wide data memory.
// For each operand: read the two operand bytes, launch the converter, wait for its done, then write back the two result bytes.
// Sits between the top-level start/done handshake and the converter core.
// Owns the single data-memory port while busy.
// PARAMETERS
// AW        8    data-memory address width
// CW        6    batch count width (max 2**CW-1 operands)
// SRC_BASE  0    address of operand 0 low byte (high byte at +1)
// DST_BASE  2    address of result 0 low byte (high byte at +1)
// STRIDE    4    address step between consecutive operands/results
// TIMEOUT   255  max WAIT cycles before the converter is declared hung
// PORTS
// clk         in   1    clock, rising edge
// reset       in   1    asynchronous, active-low reset
// start       in   1    batch request; sampled only in IDLE/DONE
// count       in   CW   number of operands; latched on accepted start
// done        out  1    level; high in DONE until next accepted start
// busy        out  1    high in any state other than IDLE/DONE
// timeout     out  1    sticky; set if any operand timed out this batch
// mem_addr    out  AW   data-memory address
// mem_wr_en   out  1    data-memory write enable
// mem_wdata   out  8    data-memory write byte
// mem_rdata   in   8    data-memory read byte (combinational read of mem_addr)
// cv_start    out  1    one-cycle converter launch pulse
// cv_operand  out  16   operand to converter; stable from LAUNCH through WAIT
// cv_done     in   1    converter completion; sampled only in WAIT
// cv_result   in   16   converter result; valid when cv_done=1
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE. All outputs 0, idx=0, op/res regs=0. Any in-flight write is abandoned.
// - States: IDLE, RD_LO, RD_HI, LAUNCH, WAIT, WR_LO, WR_HI, DONE.
// - IDLE/DONE with start=1: latch count, idx<=0, clear done and timeout.
//   - If count==0, go to DONE (done=1 next cycle); else go to RD_LO.
// - start while busy is ignored.
// - RD_LO: mem_addr=SRC_BASE+STRIDE*idx; capture mem_rdata into op[7:0].
// - RD_HI: mem_addr=same+1; capture mem_rdata into op[15:8].
// - LAUNCH: cv_start=1 for exactly this cycle; cv_operand=op. Load wait counter=0.
// - WAIT:
//   - cv_done=1: capture cv_result into res, go to WR_LO.
//   - Else counter++. When counter==TIMEOUT: res<=16'h7E00 (NaN), timeout<=1, go to WR_LO.
// - WR_LO: mem_wr_en=1, mem_addr=DST_BASE+STRIDE*idx, mem_wdata=res[7:0].
// - WR_HI: mem_wr_en=1, mem_addr=that+1, mem_wdata=res[15:8].
//   - If idx==count-1, go to DONE; else idx++ and go to RD_LO.
// - mem_wr_en is 1 only in WR_LO/WR_HI. mem_addr=0 in IDLE/DONE.
// - Address arithmetic is modulo 2**AW and wraps silently.
// - cv_done asserted outside WAIT (including in the LAUNCH cycle) is ignored.
// - Latency: a 1-cycle converter (done in the first WAIT cycle) gives 6 cycles per operand.
//   - done rises 6*count+1 cycles after the accepted start edge.
// - Reset asserted mid-batch: immediate return to IDLE. Memory contents already written remain; no partial result byte is written afterward.
// TESTING
// - count=1, mem[1:0]=8'h00,8'h30, converter returns 16'h3200 one cycle after cv_start.
//   -> mem[2]=8'h00, mem[3]=8'h32; done=1 exactly 7 cycles after start; timeout=0.
// - count=3, operands 16'h0001/16'h7FFF/16'h8000 at addr 0/4/8.
//   -> results at 2-3/6-7/10-11; exactly 3 cv_start pulses; done after 19 cycles.
// - Converter never asserts cv_done, count=1.
//   -> after 255 WAIT cycles mem[3:2]=16'h7E00; timeout=1 until next start.
// - count=0 with start -> done=1 next cycle; no cv_start; no memory writes.
// - start pulsed during WAIT -> ignored; batch result and timing unchanged.
//   - Also: cv_done=1 during LAUNCH only -> still waits for cv_done in WAIT.
// - reset=0 during WR_LO of operand 2 of 3.
//   -> outputs 0 asynchronously; operand-1 results intact; no further writes; fresh start works.

Source files
------------

// File: rtl/fx2fp_batch_ctrl.sv
// fx2fp_batch_ctrl: sequences the fixed(8.8)->float16 converter over a batch of operands in byte-wide data memory
// Ports: clk; reset (async, active-low); start/count (batch request, count latched on accept);
//   done (level, high in DONE) / busy / timeout (sticky per batch);
//   mem_addr/mem_wr_en/mem_wdata/mem_rdata (single data-memory port, combinational read);
//   cv_start (launch pulse) / cv_operand / cv_done / cv_result (converter core handshake)
module fx2fp_batch_ctrl #(
  parameter int AW       = 8,
  parameter int CW       = 6,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 2,
  parameter int STRIDE   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          done,
  output logic          busy,
  output logic          timeout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          cv_start,
  output logic [15:0]   cv_operand,
  input  logic          cv_done,
  input  logic [15:0]   cv_result
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] SB = AW'(SRC_BASE);
  localparam logic [AW-1:0] DB = AW'(DST_BASE);
  localparam logic [AW-1:0] ST = AW'(STRIDE);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, LAUNCH, WAIT, WR_LO, WR_HI, DONE} state_t;
  state_t state;
  logic [CW-1:0] idx, cnt_l;
  logic [15:0] op, res;
  logic [WW-1:0] wcnt;
  logic [AW-1:0] dst_a, src_n;
  assign dst_a = DB + ST * AW'(idx);
  assign src_n = SB + ST * AW'(idx + CW'(1));
  assign cv_operand = op;
  assign mem_wdata = state == WR_LO ? res[7:0] : state == WR_HI ? res[15:8] : 8'h00;
  // Outputs are loaded on the transition into the state that owns them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt_l     <= '0;
      op        <= '0;
      res       <= '0;
      wcnt      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      cv_start  <= 1'b0;
    end else begin
      cv_start  <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          cnt_l   <= count;
          idx     <= '0;
          timeout <= 1'b0;
          done    <= count == '0;
          busy    <= count != '0;
          state   <= count == '0 ? DONE : RD_LO;
          mem_addr <= count == '0 ? '0 : SB;
        end
        RD_LO: begin
          op[7:0]  <= mem_rdata;
          mem_addr <= mem_addr + AW'(1);
          state    <= RD_HI;
        end
        RD_HI: begin
          op[15:8] <= mem_rdata;
          mem_addr <= '0;
          cv_start <= 1'b1;
          state    <= LAUNCH;
        end
        LAUNCH: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: if (cv_done || wcnt == WW'(TIMEOUT - 1)) begin
          res       <= cv_done ? cv_result : 16'h7E00;
          timeout   <= timeout | ~cv_done;
          mem_addr  <= dst_a;
          mem_wr_en <= 1'b1;
          state     <= WR_LO;
        end else begin
          wcnt <= wcnt + WW'(1);
        end
        WR_LO: begin
          mem_addr  <= mem_addr + AW'(1);
          mem_wr_en <= 1'b1;
          state     <= WR_HI;
        end
        WR_HI: if (idx == cnt_l - CW'(1)) begin
          done     <= 1'b1;
          busy     <= 1'b0;
          mem_addr <= '0;
          state    <= DONE;
        end else begin
          idx      <= idx + CW'(1);
          mem_addr <= src_n;
          state    <= RD_LO;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
